// File: rtl/round_robin_arbiter_4.sv
// round_robin_arbiter_4: four-requester round-robin arbiter with bounded hold.
// A grant is issued one cycle after a request is sampled. It is held until the
// holder signals done, drops its request, the arbiter is disabled, or MAX_HOLD
// cycles elapse (forced release, flagged by a one-cycle timeout pulse). Every
// release is followed by one dead cycle before the next grant.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   arbiter enable; low blocks new grants and revokes the current one
//   req[3:0] in   request vector, bit i = requester i
//   done     in   current holder releases the resource
//   gnt[3:0] out  one-hot grant (all zero when idle)
//   gnt_id   out  index of current/last grant holder
//   busy     out  high while a grant is active
//   timeout  out  one-cycle pulse after a forced release at MAX_HOLD
module round_robin_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [1:0]       cand_c;
  logic [1:0]       pick_id_c;
  logic             pick_found_c;
  logic             normal_rel_c;
  logic             hold_hit_c;

  // Round-robin search: ptr+1 first, ptr itself last. Iterating from the
  // farthest offset down lets the nearest requester win.
  always_comb begin
    cand_c       = ptr_q;
    pick_id_c    = ptr_q;
    pick_found_c = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_c = ptr_q + 2'(i);
      if (req[cand_c]) begin
        pick_found_c = 1'b1;
        pick_id_c    = cand_c;
      end
    end
  end

  // Release causes; a timeout counts as forced only when no normal cause is present.
  assign normal_rel_c = done || !req[gnt_id_q] || !en;
  assign hold_hit_c   = (hold_cnt_q == HOLD_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_id_d   = gnt_id_q;
    gnt_d      = 4'b0000;
    busy_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_found_c) begin
          state_d    = GRANT;
          gnt_id_d   = pick_id_c;
          gnt_d      = 4'b0001 << pick_id_c;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (normal_rel_c || hold_hit_c) begin
          state_d    = IDLE;
          ptr_d      = gnt_id_q;
          hold_cnt_d = '0;
          timeout_d  = !normal_rel_c;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
          gnt_d      = 4'b0001 << gnt_id_q;
          busy_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; ptr resets to 3 so index 0 is favoured first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      gnt_id_q   <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Directed bench for round_robin_arbiter_4 (MAX_HOLD = 8).
module tb_round_robin_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  round_robin_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Grant, id, busy and timeout in one shot.
  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
    chk({tag, ".gnt"},     gnt,                eg);
    chk({tag, ".gnt_id"},  {2'b00, gnt_id},    {2'b00, eid});
    chk({tag, ".busy"},    {3'b000, busy},     {3'b000, eb});
    chk({tag, ".timeout"}, {3'b000, timeout},  {3'b000, et});
  endtask

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rr_seq [4];
    rr_seq[0] = 4'b0010;
    rr_seq[1] = 4'b0100;
    rr_seq[2] = 4'b1000;
    rr_seq[3] = 4'b0001;

    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    step();
    step();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Priority after reset: index 0 first, then rotate.
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 4'b1111;
    step();
    chk_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      done = 1'b1;
      step();
      chk_all("rr_dead", 4'b0000, (k == 0) ? 2'd0 : 2'(k), 1'b0, 1'b0);
      done = 1'b0;
      step();
      chk("rr_gnt", gnt, rr_seq[k]);
    end

    // Skip non-requesters and wrap 3 -> 0.
    done = 1'b1;
    req  = 4'b1001;
    step();
    chk("skip_dead.gnt", gnt, 4'b0000);
    done = 1'b0;
    step();
    chk_all("skip_gnt3", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk("skip_dead2.busy", {3'b000, busy}, 4'b0000);
    done = 1'b0;
    step();
    chk_all("wrap_gnt0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Holder 0 drops its request: release on the next edge.
    req = 4'b0010;
    step();
    chk_all("req_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout: 8 cycles of grant, then a timeout pulse with GNT low.
    step();
    for (int k = 0; k < 8; k++) begin
      chk_all("hold", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
    end
    chk_all("timeout_pulse", 4'b0000, 2'd1, 1'b0, 1'b1);
    step();
    chk_all("regrant_after_to", 4'b0010, 2'd1, 1'b1, 1'b0);

    // DONE coincides with the last hold cycle: normal release, no timeout.
    for (int k = 0; k < 7; k++) step();
    chk("last_hold.gnt", gnt, 4'b0010);
    done = 1'b1;
    step();
    chk_all("done_at_limit", 4'b0000, 2'd1, 1'b0, 1'b0);
    done = 1'b0;

    // EN low revokes the grant and blocks new ones.
    step();
    chk("pre_en.gnt", gnt, 4'b0010);
    en = 1'b0;
    step();
    chk_all("en_drop", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    step();
    chk_all("en_low_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    en = 1'b1;
    step();
    chk_all("en_back", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Reset mid-grant drops GNT immediately; index 0 favoured afterwards.
    req = 4'b0100;
    step();
    chk("to2_dead.gnt", gnt, 4'b0000);
    step();
    chk_all("gnt2", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    req   = 4'b0101;
    rst_n = 1'b1;
    chk("post_reset_idle.gnt", gnt, 4'b0000);
    step();
    chk_all("post_reset_gnt0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_4.md
ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum cycles a grant is held before forced release (legal range 2..15).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 EN  input  1  arbiter enable; 0 blocks new grants and revokes the current grant.
REQ-005 REQ  input  4  request vector, bit i = requester i.
REQ-006 DONE  input  1  current grant holder releases the resource.
REQ-007 GNT  output  4  one-hot grant, decoded from GNT_ID; all-zero when no grant.
REQ-008 GNT_ID  output  2  index of the current grant holder; holds the last value when idle.
REQ-009 BUSY  output  1  1 while a grant is active.
REQ-010 TIMEOUT  output  1  one-cycle pulse on a forced release at MAX_HOLD.

Function
REQ-011 Two-state FSM SHALL be implemented: IDLE, GRANT.
REQ-012 Internal 2-bit PTR SHALL hold the last granted index; 4-bit HOLD_CNT SHALL count grant cycles.
REQ-013 In IDLE with EN=1 and REQ!=0, the next edge SHALL grant the first set REQ bit searching PTR+1, PTR+2, PTR+3, PTR (mod 4), and enter GRANT.
REQ-014 Grant latency SHALL be exactly 1 cycle from REQ sampled high to GNT high.
REQ-015 In IDLE with EN=0 or REQ=0, the FSM SHALL remain in IDLE with GNT=0.
REQ-016 GNT SHALL equal decode(GNT_ID) when BUSY=1 and 4'b0000 otherwise; GNT SHALL never have more than one bit set.
REQ-017 BUSY SHALL be 1 exactly when the state is GRANT.
REQ-018 HOLD_CNT SHALL load 0 on grant entry and increment by 1 on each cycle spent in GRANT.
REQ-019 In GRANT, release SHALL occur on the next edge if any of the following is true: DONE=1, REQ[GNT_ID]=0, EN=0, or HOLD_CNT=MAX_HOLD-1.
REQ-020 On release, the FSM SHALL return to IDLE, GNT SHALL become 0, PTR SHALL be loaded with GNT_ID, and HOLD_CNT SHALL be cleared.
REQ-021 After every release, one dead cycle SHALL occur (GNT=0, BUSY=0) before the next grant.
REQ-022 TIMEOUT SHALL pulse high for the one cycle following a release caused only by HOLD_CNT=MAX_HOLD-1.
REQ-023 If DONE, REQ drop or EN=0 coincides with the timeout condition, the release SHALL be treated as normal and TIMEOUT SHALL stay 0.
REQ-024 Changes on REQ bits other than GNT_ID during GRANT SHALL be ignored; no preemption.
REQ-025 A grant held for MAX_HOLD cycles SHALL show GNT high for exactly MAX_HOLD consecutive cycles.
REQ-026 The PTR search SHALL wrap 3 -> 0.
REQ-027 A sole requester SHALL be re-granted after each dead cycle.

Reset
REQ-028 RST_N=0 SHALL immediately and asynchronously force: state=IDLE, GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0, HOLD_CNT=0, PTR=3 (index 0 gets first priority).
REQ-029 Reset asserted mid-grant SHALL drop GNT without waiting for a clock edge; the first arbitration after release SHALL again favour index 0.
REQ-030 Deassertion of RST_N SHALL take effect at the next rising CLK; no grant SHALL be issued on the edge where RST_N rises.

Verification
REQ-031 Scenario, priority after reset: after reset, EN=1, REQ=4'b1111 -> GNT=0001 one cycle later; DONE pulse -> dead cycle -> GNT=0010, then 0100, then 1000, then 0001.
REQ-032 Scenario, skip non-requesters: PTR=0, REQ=4'b1001 -> GNT=1000, GNT_ID=3; after release -> GNT=0001 (wrap).
REQ-033 Scenario, timeout: MAX_HOLD=8, REQ=0010 held, DONE=0 -> GNT=0010 for exactly 8 cycles, then TIMEOUT=1 for 1 cycle with GNT=0, then re-grant 0010.
REQ-034 Scenario, simultaneous release: DONE=1 on the cycle where HOLD_CNT=7 -> release with TIMEOUT=0.
REQ-035 Scenario, EN and REQ drop: EN=0 during grant -> GNT=0 next edge and no new grant while EN=0; holder drops REQ -> GNT=0 next edge.
REQ-036 Scenario, reset mid-grant: RST_N=0 while GNT=0100 -> GNT=0, BUSY=0 immediately; after release with REQ=0101 -> GNT=0001.
